uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKRATE, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 9600, serial bit rate in bit/s.
REQ-003 clk  input  1  system clock; all logic on the rising edge; single clock domain.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rxd  input  1  asynchronous serial line; idle high.
REQ-006 rx_data  output  8  last received byte.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both high on a clk edge.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 overrun  output  1  sticky flag: a byte completed while rx_valid was still high; cleared only by rst.

Function
REQ-011 The block SHALL derive OSDIV = CLKRATE/(BAUDRATE*16) (integer division); tick fires once every OSDIV clk cycles; the divider counter is sized $clog2(OSDIV)+1 bits.
REQ-012 While the FSM is IDLE, the divider SHALL be held at 0; the divider restarts on the cycle start is detected.
REQ-013 rxd SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (rxs).
REQ-014 FSM states: IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-015 IDLE->START when rxs is 0 (falling edge relative to idle high).
REQ-016 START: on tick 8, if rxs=0 -> DATA with bit index 0; if rxs=1 -> IDLE (glitch reject, no flags).
REQ-017 DATA: sample rxs every 16 ticks (mid-bit), shift in LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-018 STOP: sample at mid-bit; rxs=1 -> load byte, set rx_valid, return to IDLE on the same tick; rxs=0 -> pulse frame_err for 1 cycle, discard byte, go to IDLE.
REQ-019 Latency: rx_valid rises 1 clk after the stop-bit mid-sample tick.
REQ-020 rx_valid SHALL stay high and rx_data stable until a rx_ready handshake; it clears on the cycle after the handshake.
REQ-021 A good frame completing while rx_valid=1 and no handshake on that cycle SHALL set overrun and overwrite rx_data; rx_valid stays 1.
REQ-022 A handshake and a new byte completing on the same cycle: the new byte loads, rx_valid stays 1, overrun is not set.
REQ-023 A line held low for the whole frame SHALL produce frame_err; the FSM SHALL then wait in IDLE until rxs=1 before accepting a new start.

Reset
REQ-024 On rst=1 at a clk edge: FSM=IDLE; divider, bit index and shift register = 0; rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0; both synchroniser flops=1.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no rx_valid and no frame_err; reception resumes on the next falling edge after rst=0.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: the PARITY state is compiled in; one even-parity bit is sampled after bit 7; a mismatch pulses the extra output parity_err (1 bit) for 1 cycle and discards the byte; the stop bit is still checked.
REQ-027 Macro UART_RX_PARITY_EN undefined: there is no PARITY state and no parity_err port; the frame is 8N1.

Verification (CLKRATE=50_000_000, BAUDRATE=9600, OSDIV=325, bit = 5200 clk)
REQ-028 8N1 frame 0xA5 on rxd, rx_ready=0 -> rx_valid=1 and rx_data=8'hA5 about 49,400 clk after the start edge; frame_err=0.
REQ-029 0x3C then 0x5A back-to-back, rx_ready never high -> rx_data=8'h5A and overrun=1.
REQ-030 rxd low pulse of 1000 clk, then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-031 0xFF with stop bit forced low -> frame_err pulses 1 cycle; rx_valid stays 0.
REQ-032 rst=1 at bit 4 of 0x81, then a clean 0x81 -> exactly one rx_valid, with rx_data=8'h81.
REQ-033 With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 -> parity_err pulses; rx_valid stays 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Consumer-side bundle for uart_rx: received byte, valid/ready handshake and error flags.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;

   modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ready);
   modport slave  (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ready);
`else
   modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
   modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
`endif
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity_err.
// Synchronous active-high reset; received bytes are held until a valid/ready handshake.
module uart_rx #(
   parameter int unsigned CLKRATE  = 50_000_000,
   parameter int unsigned BAUDRATE = 9600
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rxd,
   uart_rx_if.master bus
);
   localparam int unsigned OSDIV = CLKRATE / (BAUDRATE * 16);
   localparam int unsigned DIV_W = $clog2(OSDIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSDIV - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

   state_e           state_q, state_d;
   logic             sync1_q, sync2_q, rxs_prev_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       tcnt_q, tcnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic             par_bad_q, par_bad_d;
   logic             parity_err_q, parity_err_d;
`endif
   logic             rxs, tick, mid_bit, load;

   assign rxs     = sync2_q;
   assign tick    = (div_q == DIV_LAST);
   assign mid_bit = tick && (tcnt_q == 4'd15);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      tcnt_d      = tcnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      load        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif

      if (state_q == S_IDLE) begin
         div_d  = '0;
         tcnt_d = '0;
      end else begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
         if (tick) tcnt_d = tcnt_q + 4'd1;
      end

      unique case (state_q)
         // A start needs a high-to-low transition, so a line stuck low cannot retrigger.
         S_IDLE: if (rxs_prev_q && !rxs) state_d = S_START;
         S_START: if (tick && tcnt_q == 4'd7) begin
            tcnt_d = '0;
            bit_d  = '0;
            state_d = rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
         end
         S_DATA: if (mid_bit) begin
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_d = S_PARITY;
`else
            if (bit_q == 3'd7) state_d = S_STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (mid_bit) begin
            if ((^shift_q) != rxs) begin
               par_bad_d    = 1'b1;
               parity_err_d = 1'b1;
            end
            state_d = S_STOP;
         end
`endif
         S_STOP: if (mid_bit) begin
            state_d     = S_IDLE;
            frame_err_d = !rxs;
`ifdef UART_RX_PARITY_EN
            load = rxs && !par_bad_q;
`else
            load = rxs;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // A load on the handshake cycle wins, so the new byte stays valid.
      valid_d   = (valid_q && !bus.rx_ready) || load;
      data_d    = load ? shift_q : data_q;
      overrun_d = overrun_q || (load && valid_q && !bus.rx_ready);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rxs_prev_q  <= 1'b1;
         div_q       <= '0;
         tcnt_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= rxd;
         sync2_q     <= sync1_q;
         rxs_prev_q  <= sync2_q;
         div_q       <= div_d;
         tcnt_q      <= tcnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced clock/baud ratio (OSDIV = 10, one bit = 160 clk).
// Honours UART_RX_PARITY_EN: frames then carry an even-parity bit and the parity test runs.
module tb_uart_rx;
   localparam int CLKRATE  = 1_600_000;
   localparam int BAUDRATE = 10_000;
   localparam int OSDIV    = CLKRATE / (BAUDRATE * 16);
   localparam int BIT_CLKS = 16 * OSDIV;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // Start edge -> 2 sync flops + edge detect, half a bit, 8 data (+parity) + stop bits, then the rx_valid flop.
   localparam int LOAD_LAT = 3 + (8 * OSDIV - 1) + BIT_CLKS * (9 + PAR_BITS) + 1;

   logic clk = 1'b0;
   logic rst;
   logic rxd;
   int   checks = 0;
   int   errors = 0;

   uart_rx_if bus ();

   uart_rx #(.CLKRATE(CLKRATE), .BAUDRATE(BAUDRATE)) dut (
      .clk (clk),
      .rst (rst),
      .rxd (rxd),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Event counters sampled on the falling edge; tests compare before/after deltas.
   int   vld_rises = 0;
   int   fe_cycles = 0;
   logic vld_prev  = 1'b0;
`ifdef UART_RX_PARITY_EN
   int   pe_cycles = 0;
   logic par_flip  = 1'b0;
`endif
   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) fe_cycles++;
      if (bus.rx_valid === 1'b1 && vld_prev !== 1'b1) vld_rises++;
      vld_prev = bus.rx_valid;
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err === 1'b1) pe_cycles++;
`endif
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      rxd = 1'b1;
      bus.rx_ready = 1'b0;
      tick_n(3);
      rst = 1'b0;
      tick_n(2);
   endtask

   // Drives start, 8 data bits LSB first, optional parity, and the stop bit; leaves rxd at stop_val.
   task automatic send_frame(input logic [7:0] d, input logic stop_val);
      rxd = 1'b0;
      tick_n(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick_n(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^d) ^ par_flip;
      tick_n(BIT_CLKS);
`endif
      rxd = stop_val;
      tick_n(BIT_CLKS);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rxd = 1'b1;
      bus.rx_ready = 1'b0;
      tick_n(2);
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
`ifdef UART_RX_PARITY_EN
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", bus.parity_err); end
`endif
      rst = 1'b0;
      tick_n(BIT_CLKS);
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL idle_rx_valid: got %b expected 0", bus.rx_valid); end
   endtask

   task automatic test_single_byte;
      int lat, f0;
      do_reset;
      f0  = fe_cycles;
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (bus.rx_valid !== 1'b1 && lat < LOAD_LAT + 100) begin
               tick_n(1);
               lat++;
            end
         end
      join
      checks++; if (lat < LOAD_LAT - 2 || lat > LOAD_LAT + 2) begin errors++; $display("FAIL a5_latency: got %0d clk expected %0d", lat, LOAD_LAT); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL a5_rx_valid: got %b expected 1", bus.rx_valid); end
      checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h expected a5", bus.rx_data); end
      checks++; if (fe_cycles - f0 !== 0) begin errors++; $display("FAIL a5_frame_err: got %0d pulses expected 0", fe_cycles - f0); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL a5_overrun: got %b expected 0", bus.overrun); end
      tick_n(50);
      checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA5) begin errors++; $display("FAIL a5_hold: got valid %b data %h expected 1 a5", bus.rx_valid, bus.rx_data); end
      bus.rx_ready = 1'b1;
      tick_n(1);
      bus.rx_ready = 1'b0;
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL a5_consume: got %b expected 0", bus.rx_valid); end
   endtask

   task automatic test_back_to_back;
      int v0;
      do_reset;
      v0 = vld_rises;
      send_frame(8'h3C, 1'b1);
      send_frame(8'h5A, 1'b1);
      tick_n(10);
      checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL b2b_rx_data: got %h expected 5a", bus.rx_data); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_rx_valid: got %b expected 1", bus.rx_valid); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", bus.overrun); end
      checks++; if (vld_rises - v0 !== 1) begin errors++; $display("FAIL b2b_valid_rises: got %0d expected 1", vld_rises - v0); end
      bus.rx_ready = 1'b1;
      tick_n(1);
      bus.rx_ready = 1'b0;
      tick_n(5);
      checks++; if (bus.rx_valid !== 1'b0 || bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_sticky: got valid %b overrun %b expected 0 1", bus.rx_valid, bus.overrun); end
   endtask

   task automatic test_collision;
      do_reset;
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            tick_n(LOAD_LAT - 1);
            bus.rx_ready = 1'b1;
            tick_n(1);
            bus.rx_ready = 1'b0;
         end
      join
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL coll_rx_valid: got %b expected 1", bus.rx_valid); end
      checks++; if (bus.rx_data !== 8'h22) begin errors++; $display("FAIL coll_rx_data: got %h expected 22", bus.rx_data); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b expected 0", bus.overrun); end
   endtask

   task automatic test_glitch;
      int v0, f0;
      do_reset;
      v0 = vld_rises;
      f0 = fe_cycles;
      rxd = 1'b0;
      tick_n(30);
      rxd = 1'b1;
      tick_n(2 * BIT_CLKS);
      checks++; if (vld_rises - v0 !== 0 || fe_cycles - f0 !== 0) begin errors++; $display("FAIL glitch_flags: got valid %0d fe %0d expected 0 0", vld_rises - v0, fe_cycles - f0); end
      send_frame(8'h42, 1'b1);
      tick_n(10);
      checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h42) begin errors++; $display("FAIL glitch_recover: got valid %b data %h expected 1 42", bus.rx_valid, bus.rx_data); end
      checks++; if (fe_cycles - f0 !== 0) begin errors++; $display("FAIL glitch_recover_fe: got %0d expected 0", fe_cycles - f0); end
   endtask

   task automatic test_frame_error;
      int v0, f0;
      do_reset;
      v0 = vld_rises;
      f0 = fe_cycles;
      send_frame(8'hFF, 1'b0);
      tick_n(3 * BIT_CLKS);
      checks++; if (fe_cycles - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cycles - f0); end
      checks++; if (vld_rises - v0 !== 0 || bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %0d rises valid %b expected 0 0", vld_rises - v0, bus.rx_valid); end
      rxd = 1'b1;
      tick_n(BIT_CLKS);
      f0 = fe_cycles;
      rxd = 1'b0;
      tick_n(12 * BIT_CLKS);
      rxd = 1'b1;
      tick_n(BIT_CLKS);
      checks++; if (fe_cycles - f0 !== 1) begin errors++; $display("FAIL break_pulse: got %0d cycles expected 1", fe_cycles - f0); end
      checks++; if (vld_rises - v0 !== 0) begin errors++; $display("FAIL break_valid: got %0d rises expected 0", vld_rises - v0); end
      send_frame(8'h99, 1'b1);
      tick_n(10);
      checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h99) begin errors++; $display("FAIL break_recover: got valid %b data %h expected 1 99", bus.rx_valid, bus.rx_data); end
   endtask

   task automatic test_reset_mid_frame;
      int v0, f0;
      logic [7:0] d;
      d = 8'h81;
      do_reset;
      v0 = vld_rises;
      f0 = fe_cycles;
      rxd = 1'b0;
      tick_n(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rxd = d[i];
         tick_n(BIT_CLKS);
      end
      rxd = d[4];
      tick_n(BIT_CLKS / 2);
      rst = 1'b1;
      rxd = 1'b1;
      tick_n(3);
      rst = 1'b0;
      tick_n(12 * BIT_CLKS);
      checks++; if (vld_rises - v0 !== 0 || fe_cycles - f0 !== 0) begin errors++; $display("FAIL midrst_flags: got valid %0d fe %0d expected 0 0", vld_rises - v0, fe_cycles - f0); end
      send_frame(d, 1'b1);
      tick_n(10);
      checks++; if (vld_rises - v0 !== 1) begin errors++; $display("FAIL midrst_count: got %0d rises expected 1", vld_rises - v0); end
      checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL midrst_rx_data: got %h expected 81", bus.rx_data); end
      checks++; if (fe_cycles - f0 !== 0) begin errors++; $display("FAIL midrst_fe: got %0d expected 0", fe_cycles - f0); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int v0, p0, f0;
      do_reset;
      v0 = vld_rises;
      p0 = pe_cycles;
      f0 = fe_cycles;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      tick_n(20);
      checks++; if (pe_cycles - p0 !== 1) begin errors++; $display("FAIL par_pulse: got %0d cycles expected 1", pe_cycles - p0); end
      checks++; if (vld_rises - v0 !== 0 || bus.rx_valid !== 1'b0) begin errors++; $display("FAIL par_valid: got %0d rises valid %b expected 0 0", vld_rises - v0, bus.rx_valid); end
      checks++; if (fe_cycles - f0 !== 0) begin errors++; $display("FAIL par_fe: got %0d expected 0", fe_cycles - f0); end
      send_frame(8'h07, 1'b1);
      tick_n(10);
      checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h07) begin errors++; $display("FAIL par_good: got valid %b data %h expected 1 07", bus.rx_valid, bus.rx_data); end
      checks++; if (pe_cycles - p0 !== 1) begin errors++; $display("FAIL par_good_pe: got %0d expected 1", pe_cycles - p0); end
   endtask
`endif

   initial begin
      test_reset;
      test_single_byte;
      test_back_to_back;
      test_collision;
      test_glitch;
      test_frame_error;
      test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
      test_parity;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
